// File: rtl/nx_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : nx_instr_loader
// Description : Write-side front end of the dual-core instruction store.
//               Accepts instruction chunks (least-significant first) over a
//               valid/ready handshake, reassembles them into one instruction
//               and emits a single-cycle store write strobe per instruction.
//               Keeps saturating per-core load counts, drops instructions
//               aimed at a full core (sticky overflow) and flags a core-select
//               change in the middle of an instruction (sticky error).
//
// Ports       : clk_i            clock
//               rst_i            synchronous active-high reset
//               msg_data_i       inbound instruction chunk
//               msg_core_i       target core of the inbound chunk
//               msg_valid_i      inbound chunk valid
//               msg_ready_o      loader can accept a chunk
//               clear_i          abort assembly, zero counts and flags
//               store_core_o     target core of the emitted instruction
//               store_data_o     assembled instruction
//               store_valid_o    single-cycle write strobe
//               core_0_loaded_o  instructions written to core 0
//               core_1_loaded_o  instructions written to core 1
//               overflow_o       sticky: instruction dropped, core full
//               error_o          sticky: core select changed mid-instruction
//
// Revision    : 1.0 - initial release
// ============================================================================
module nx_instr_loader #(
    parameter int INSTR_WIDTH = 15,
    parameter int MAX_INSTRS  = 512,
    parameter int CHUNK_WIDTH = 8,
    localparam int CW         = $clog2(MAX_INSTRS) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CHUNK_WIDTH-1:0] msg_data_i,
    input  logic                   msg_core_i,
    input  logic                   msg_valid_i,
    output logic                   msg_ready_o,
    input  logic                   clear_i,
    output logic                   store_core_o,
    output logic [INSTR_WIDTH-1:0] store_data_o,
    output logic                   store_valid_o,
    output logic [CW-1:0]          core_0_loaded_o,
    output logic [CW-1:0]          core_1_loaded_o,
    output logic                   overflow_o,
    output logic                   error_o
);

    localparam int NUM_CHUNKS = (INSTR_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    // Index must be able to hold NUM_CHUNKS itself, not just NUM_CHUNKS-1.
    localparam int IDX_W      = (NUM_CHUNKS < 2) ? 1 : $clog2(NUM_CHUNKS + 1);

    localparam logic [1:0]       c_idle     = 2'd0;
    localparam logic [1:0]       c_assemble = 2'd1;
    localparam logic [1:0]       c_emit     = 2'd2;

    localparam logic             c_single   = (NUM_CHUNKS == 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [IDX_W-1:0] c_one_idx  = IDX_W'(1);
    localparam logic [CW-1:0]    c_max      = CW'(MAX_INSTRS);

    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [INSTR_WIDTH-1:0] r_asm;
    logic                   r_core;
    logic                   r_store_core;
    logic [INSTR_WIDTH-1:0] r_store_data;
    logic                   r_store_valid;
    logic [CW-1:0]          r_cnt0;
    logic [CW-1:0]          r_cnt1;
    logic                   r_ovf;
    logic                   r_err;

    logic                   w_xfer;
    logic [INSTR_WIDTH-1:0] w_asm_fill;
    logic [INSTR_WIDTH-1:0] w_asm_first;

    assign msg_ready_o = !rst_i && !clear_i && (r_state != c_emit);
    assign w_xfer      = msg_valid_i && msg_ready_o;

    // The assembly register only keeps INSTR_WIDTH bits; chunk bits that land
    // above the instruction width are never stored, which is how the excess
    // top-chunk bits get discarded.
    generate
        for (genvar b = 0; b < INSTR_WIDTH; b++) begin : g_bits
            localparam int c_chunk = b / CHUNK_WIDTH;
            localparam int c_bit   = b % CHUNK_WIDTH;
            // Fill the slice selected by the current index, keep the rest.
            assign w_asm_fill[b]  = (r_idx == IDX_W'(c_chunk)) ? msg_data_i[c_bit] : r_asm[b];
            // Start of a new instruction: slice 0 only, everything else zero.
            assign w_asm_first[b] = (c_chunk == 0) ? msg_data_i[c_bit] : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_idle;
            r_idx         <= '0;
            r_asm         <= '0;
            r_core        <= 1'b0;
            r_store_core  <= 1'b0;
            r_store_data  <= '0;
            r_store_valid <= 1'b0;
            r_cnt0        <= '0;
            r_cnt1        <= '0;
            r_ovf         <= 1'b0;
            r_err         <= 1'b0;
        end else if (clear_i) begin
            // Store data/core outputs intentionally hold their last values.
            r_state       <= c_idle;
            r_idx         <= '0;
            r_asm         <= '0;
            r_store_valid <= 1'b0;
            r_cnt0        <= '0;
            r_cnt1        <= '0;
            r_ovf         <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_store_valid <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_xfer) begin
                        r_core  <= msg_core_i;
                        r_asm   <= w_asm_first;
                        r_idx   <= c_one_idx;
                        r_state <= c_single ? c_emit : c_assemble;
                    end
                end
                c_assemble: begin
                    if (w_xfer) begin
                        if (msg_core_i != r_core) begin
                            // Drop the partial instruction; the offending
                            // chunk becomes slice 0 of a fresh one.
                            r_err   <= 1'b1;
                            r_core  <= msg_core_i;
                            r_asm   <= w_asm_first;
                            r_idx   <= c_one_idx;
                            r_state <= c_single ? c_emit : c_assemble;
                        end else begin
                            r_asm <= w_asm_fill;
                            r_idx <= r_idx + c_one_idx;
                            if (r_idx == c_last_idx) begin
                                r_state <= c_emit;
                            end
                        end
                    end
                end
                c_emit: begin
                    if (r_core == 1'b0) begin
                        if (r_cnt0 < c_max) begin
                            r_store_valid <= 1'b1;
                            r_store_data  <= r_asm;
                            r_store_core  <= 1'b0;
                            r_cnt0        <= r_cnt0 + CW'(1);
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end else begin
                        if (r_cnt1 < c_max) begin
                            r_store_valid <= 1'b1;
                            r_store_data  <= r_asm;
                            r_store_core  <= 1'b1;
                            r_cnt1        <= r_cnt1 + CW'(1);
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                    r_idx   <= '0;
                    r_state <= c_idle;
                end
                default: begin
                    r_idx   <= '0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign store_core_o    = r_store_core;
    assign store_data_o    = r_store_data;
    assign store_valid_o   = r_store_valid;
    assign core_0_loaded_o = r_cnt0;
    assign core_1_loaded_o = r_cnt1;
    assign overflow_o      = r_ovf;
    assign error_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nx_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_nx_instr_loader
// Description : Directed self-checking bench for nx_instr_loader. Instance
//               "a" uses default parameters, instance "b" uses MAX_INSTRS=4
//               for the capacity / overflow scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nx_instr_loader;

    logic        clk;
    logic        rst;

    // Instance a (default parameters, count width 10)
    logic [7:0]  a_data;
    logic        a_core;
    logic        a_valid;
    logic        a_ready;
    logic        a_clear;
    logic        a_score;
    logic [14:0] a_sdata;
    logic        a_svalid;
    logic [9:0]  a_cnt0;
    logic [9:0]  a_cnt1;
    logic        a_ovf;
    logic        a_err;

    // Instance b (MAX_INSTRS=4, count width 3)
    logic [7:0]  b_data;
    logic        b_core;
    logic        b_valid;
    logic        b_ready;
    logic        b_clear;
    logic        b_score;
    logic [14:0] b_sdata;
    logic        b_svalid;
    logic [2:0]  b_cnt0;
    logic [2:0]  b_cnt1;
    logic        b_ovf;
    logic        b_err;

    int checks   = 0;
    int failures = 0;

    nx_instr_loader u_a (
        .clk_i           (clk),
        .rst_i           (rst),
        .msg_data_i      (a_data),
        .msg_core_i      (a_core),
        .msg_valid_i     (a_valid),
        .msg_ready_o     (a_ready),
        .clear_i         (a_clear),
        .store_core_o    (a_score),
        .store_data_o    (a_sdata),
        .store_valid_o   (a_svalid),
        .core_0_loaded_o (a_cnt0),
        .core_1_loaded_o (a_cnt1),
        .overflow_o      (a_ovf),
        .error_o         (a_err)
    );

    nx_instr_loader #(.MAX_INSTRS(4)) u_b (
        .clk_i           (clk),
        .rst_i           (rst),
        .msg_data_i      (b_data),
        .msg_core_i      (b_core),
        .msg_valid_i     (b_valid),
        .msg_ready_o     (b_ready),
        .clear_i         (b_clear),
        .store_core_o    (b_score),
        .store_data_o    (b_sdata),
        .store_valid_o   (b_svalid),
        .core_0_loaded_o (b_cnt0),
        .core_1_loaded_o (b_cnt1),
        .overflow_o      (b_ovf),
        .error_o         (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Two-chunk instruction into instance b, followed by the EMIT cycle.
    task automatic send_b(input logic core, input logic [7:0] lo, input logic [7:0] hi);
        b_valid = 1'b1; b_core = core; b_data = lo;
        step();
        b_data = hi;
        step();
        b_valid = 1'b0;
        step();
    endtask

    logic [15:0] exp_word;

    initial begin
        rst = 1'b1;
        a_data = '0; a_core = 1'b0; a_valid = 1'b0; a_clear = 1'b0;
        b_data = '0; b_core = 1'b0; b_valid = 1'b0; b_clear = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_ready",  32'(a_ready),  32'd0);
        chk("rst_svalid", 32'(a_svalid), 32'd0);
        chk("rst_sdata",  32'(a_sdata),  32'd0);
        chk("rst_score",  32'(a_score),  32'd0);
        chk("rst_cnt0",   32'(a_cnt0),   32'd0);
        chk("rst_cnt1",   32'(a_cnt1),   32'd0);
        chk("rst_flags",  32'({a_ovf, a_err}), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(a_ready), 32'd1);

        // ---------------- single instruction, core 0 ----------------
        a_valid = 1'b1; a_core = 1'b0; a_data = 8'hAB;
        step();
        chk("t1_ready_asm", 32'(a_ready), 32'd1);
        a_data = 8'h7C;
        step();
        chk("t1_ready_emit", 32'(a_ready), 32'd0);
        chk("t1_no_strobe_yet", 32'(a_svalid), 32'd0);
        a_valid = 1'b0;
        step();
        chk("t1_strobe", 32'(a_svalid), 32'd1);
        chk("t1_data",   32'(a_sdata),  32'h7CAB);
        chk("t1_core",   32'(a_score),  32'd0);
        chk("t1_cnt0",   32'(a_cnt0),   32'd1);
        step();
        chk("t1_strobe_single", 32'(a_svalid), 32'd0);
        chk("t1_data_hold",     32'(a_sdata),  32'h7CAB);

        // ---------------- back-to-back, core 1, valid held ----------------
        // Top chunk has bit 7 set so truncation to 15 bits is exercised.
        a_valid = 1'b1; a_core = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'(8'h10 + i);
            chk("t2_ready_lo", 32'(a_ready), 32'd1);
            step();
            a_data = 8'(8'h80 | i);
            chk("t2_ready_hi", 32'(a_ready), 32'd1);
            step();
            chk("t2_ready_emit", 32'(a_ready), 32'd0);
            a_data = 8'hEE;   // offered during EMIT, must not be taken
            step();
            exp_word = {8'(8'h80 | i), 8'(8'h10 + i)} & 16'h7FFF;
            chk("t2_strobe", 32'(a_svalid), 32'd1);
            chk("t2_data",   32'(a_sdata),  32'(exp_word[14:0]));
            chk("t2_core",   32'(a_score),  32'd1);
        end
        a_valid = 1'b0;
        step();
        chk("t2_cnt1", 32'(a_cnt1), 32'd4);
        chk("t2_cnt0", 32'(a_cnt0), 32'd1);
        chk("t2_err",  32'(a_err),  32'd0);

        // ---------------- core mismatch ----------------
        a_valid = 1'b1; a_core = 1'b0; a_data = 8'h11;
        step();
        a_core = 1'b1; a_data = 8'h22;
        step();
        chk("t3_err",       32'(a_err),    32'd1);
        chk("t3_no_strobe", 32'(a_svalid), 32'd0);
        chk("t3_ready",     32'(a_ready),  32'd1);
        a_data = 8'h33;
        step();
        a_valid = 1'b0;
        step();
        chk("t3_strobe", 32'(a_svalid), 32'd1);
        chk("t3_data",   32'(a_sdata),  32'h3322);
        chk("t3_core",   32'(a_score),  32'd1);
        chk("t3_cnt1",   32'(a_cnt1),   32'd5);
        chk("t3_cnt0",   32'(a_cnt0),   32'd1);

        // ---------------- clear during EMIT ----------------
        a_valid = 1'b1; a_core = 1'b0; a_data = 8'h44;
        step();
        a_data = 8'h55;
        step();
        a_valid = 1'b0; a_clear = 1'b1;
        chk("t5_ready_clear", 32'(a_ready), 32'd0);
        step();
        chk("t5_no_strobe", 32'(a_svalid), 32'd0);
        chk("t5_cnt0",      32'(a_cnt0),   32'd0);
        chk("t5_cnt1",      32'(a_cnt1),   32'd0);
        chk("t5_flags",     32'({a_ovf, a_err}), 32'd0);
        chk("t5_data_hold", 32'(a_sdata),  32'h3322);
        a_clear = 1'b0;
        #1;
        chk("t5_ready_after", 32'(a_ready), 32'd1);
        step();
        chk("t5_still_quiet", 32'(a_svalid), 32'd0);

        // ---------------- reset after first chunk ----------------
        a_valid = 1'b1; a_core = 1'b0; a_data = 8'hFF;
        step();
        a_valid = 1'b0; rst = 1'b1;
        step();
        chk("t6_rst_sdata",  32'(a_sdata),  32'd0);
        chk("t6_rst_svalid", 32'(a_svalid), 32'd0);
        rst = 1'b0;
        a_valid = 1'b1; a_data = 8'h01;
        step();
        a_valid = 1'b0;         // gap between chunks, assembly must wait
        step();
        step();
        chk("t6_gap_no_strobe", 32'(a_svalid), 32'd0);
        a_valid = 1'b1; a_data = 8'h02;
        step();
        a_valid = 1'b0;
        step();
        chk("t6_strobe", 32'(a_svalid), 32'd1);
        chk("t6_data",   32'(a_sdata),  32'h0201);
        chk("t6_cnt0",   32'(a_cnt0),   32'd1);

        // ---------------- capacity, MAX_INSTRS=4 (instance b) ----------------
        for (int i = 0; i < 5; i++) begin
            send_b(1'b0, 8'(8'h20 + i), 8'h05);
            chk("t4_strobe", 32'(b_svalid), (i < 4) ? 32'd1 : 32'd0);
            chk("t4_ovf",    32'(b_ovf),    (i < 4) ? 32'd0 : 32'd1);
        end
        chk("t4_last_data", 32'(b_sdata), 32'h0523);
        chk("t4_cnt0",      32'(b_cnt0),  32'd4);
        send_b(1'b1, 8'h66, 8'h07);
        chk("t4_c1_strobe", 32'(b_svalid), 32'd1);
        chk("t4_c1_data",   32'(b_sdata),  32'h0766);
        chk("t4_c1_core",   32'(b_score),  32'd1);
        chk("t4_c1_cnt1",   32'(b_cnt1),   32'd1);
        chk("t4_c1_cnt0",   32'(b_cnt0),   32'd4);
        chk("t4_ovf_stick", 32'(b_ovf),    32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
